// File: rtl/ai_host_master_if.sv
// Signal bundle between game logic, the ai_host_master block and the
// Avalon-MM AI accelerator. The "master" modport is the view taken by
// ai_host_master (it masters the Avalon bus and serves the game request);
// the "slave" modport is the view of everything around it.
interface ai_host_master_if;
    // Game-side request and board snapshot inputs
    logic         req;
    logic [99:0]  fired_in;
    logic [99:0]  hits_in;
    logic [4:0]   ships_in;

    // Game-side status / result
    logic         busy;
    logic         done;
    logic [6:0]   target_index;
    logic         err;

    // Avalon-MM bus to the accelerator
    logic [2:0]   avm_address;
    logic         avm_write;
    logic         avm_read;
    logic [63:0]  avm_writedata;
    logic [63:0]  avm_readdata;
    logic         avm_waitrequest;

    modport master (
        input  req,
        input  fired_in,
        input  hits_in,
        input  ships_in,
        input  avm_readdata,
        input  avm_waitrequest,
        output busy,
        output done,
        output target_index,
        output err,
        output avm_address,
        output avm_write,
        output avm_read,
        output avm_writedata
    );

    modport slave (
        output req,
        output fired_in,
        output hits_in,
        output ships_in,
        output avm_readdata,
        output avm_waitrequest,
        input  busy,
        input  done,
        input  target_index,
        input  err,
        input  avm_address,
        input  avm_write,
        input  avm_read,
        input  avm_writedata
    );
endinterface

// File: rtl/ai_host_master.sv
// ai_host_master: takes a one-cycle shot request from game logic, snapshots
// the board, pushes it to the AI accelerator over Avalon-MM, kicks off the
// computation, waits for it (with a timeout), reads back the recommended
// cell and reports it with a one-cycle done pulse.
module ai_host_master #(
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic             clock,
    input  logic             reset,
    ai_host_master_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_F0,
        S_WR_F1,
        S_WR_H0,
        S_WR_H1,
        S_WR_SHIPS,
        S_WR_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RD,
        S_FINISH
    } state_t;

    // Accelerator register map
    localparam logic [2:0] ADDR_CTRL   = 3'd0;  // write: start, read: result
    localparam logic [2:0] ADDR_FIRED0 = 3'd1;
    localparam logic [2:0] ADDR_FIRED1 = 3'd2;
    localparam logic [2:0] ADDR_HITS0  = 3'd3;
    localparam logic [2:0] ADDR_HITS1  = 3'd4;
    localparam logic [2:0] ADDR_SHIPS  = 3'd5;

    localparam logic [11:0] TIMEOUT_LIMIT = 12'(TIMEOUT_CYCLES);
    localparam logic [6:0]  LAST_CELL     = 7'd99;

    state_t        state_q;
    logic [99:0]   fired_q;
    logic [99:0]   hits_q;
    logic [4:0]    ships_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [6:0]    target_q;
    logic [2:0]    avm_address_q;
    logic          avm_write_q;
    logic          avm_read_q;
    logic [63:0]   avm_writedata_q;
    logic [11:0]   wait_cnt_q;
    logic [11:0]   wait_cnt_d;

    logic          xfer_ok;
    logic          timeout_hit;
    logic [6:0]    rd_value;

    // The low half of the fired snapshot is sent straight from the input
    // on the acceptance edge, so its stored copy is never read back.
    logic          unused_bits;
    assign unused_bits = ^{fired_q[49:0], bus.avm_readdata[63:7]};

    // Wait counter next value and transfer/timeout qualifiers
    always_comb begin
        wait_cnt_d  = wait_cnt_q + 12'd1;
        timeout_hit = (wait_cnt_d == TIMEOUT_LIMIT);
        xfer_ok     = ~bus.avm_waitrequest;
        rd_value    = bus.avm_readdata[6:0];
    end

    // Request sequencer: FSM with all bus and status outputs registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            fired_q         <= '0;
            hits_q          <= '0;
            ships_q         <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            target_q        <= '0;
            avm_address_q   <= '0;
            avm_write_q     <= 1'b0;
            avm_read_q      <= 1'b0;
            avm_writedata_q <= '0;
            wait_cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        fired_q <= bus.fired_in;
                        hits_q  <= bus.hits_in;
                        ships_q <= bus.ships_in;
                        if (bus.ships_in == 5'd0) begin
                            // Nothing afloat: no point asking the accelerator.
                            // busy never rises; done arrives next cycle.
                            state_q  <= S_FINISH;
                            done_q   <= 1'b1;
                            err_q    <= 1'b1;
                            target_q <= '0;
                        end else begin
                            // First beat is launched from the live inputs,
                            // which equal the snapshot taken on this edge.
                            state_q         <= S_WR_F0;
                            busy_q          <= 1'b1;
                            avm_write_q     <= 1'b1;
                            avm_address_q   <= ADDR_FIRED0;
                            avm_writedata_q <= {14'd0, bus.fired_in[49:0]};
                        end
                    end
                end

                S_WR_F0: begin
                    if (xfer_ok) begin
                        state_q         <= S_WR_F1;
                        avm_address_q   <= ADDR_FIRED1;
                        avm_writedata_q <= {14'd0, fired_q[99:50]};
                    end
                end

                S_WR_F1: begin
                    if (xfer_ok) begin
                        state_q         <= S_WR_H0;
                        avm_address_q   <= ADDR_HITS0;
                        avm_writedata_q <= {14'd0, hits_q[49:0]};
                    end
                end

                S_WR_H0: begin
                    if (xfer_ok) begin
                        state_q         <= S_WR_H1;
                        avm_address_q   <= ADDR_HITS1;
                        avm_writedata_q <= {14'd0, hits_q[99:50]};
                    end
                end

                S_WR_H1: begin
                    if (xfer_ok) begin
                        state_q         <= S_WR_SHIPS;
                        avm_address_q   <= ADDR_SHIPS;
                        avm_writedata_q <= {59'd0, ships_q};
                    end
                end

                S_WR_SHIPS: begin
                    if (xfer_ok) begin
                        state_q         <= S_WR_START;
                        avm_address_q   <= ADDR_CTRL;
                        avm_writedata_q <= '0;
                    end
                end

                S_WR_START: begin
                    if (xfer_ok) begin
                        state_q     <= S_WAIT_ACK;
                        avm_write_q <= 1'b0;
                        wait_cnt_q  <= '0;
                    end
                end

                // Accelerator signals "computing" by raising waitrequest
                S_WAIT_ACK: begin
                    wait_cnt_q <= wait_cnt_d;
                    if (bus.avm_waitrequest) begin
                        state_q <= S_WAIT_DONE;
                    end else if (timeout_hit) begin
                        state_q  <= S_FINISH;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        target_q <= '0;
                    end
                end

                // Computation finished once waitrequest falls again; a
                // result arriving on the timeout cycle itself still wins.
                S_WAIT_DONE: begin
                    wait_cnt_q <= wait_cnt_d;
                    if (!bus.avm_waitrequest) begin
                        state_q       <= S_RD;
                        avm_read_q    <= 1'b1;
                        avm_address_q <= ADDR_CTRL;
                    end else if (timeout_hit) begin
                        state_q  <= S_FINISH;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        target_q <= '0;
                    end
                end

                S_RD: begin
                    if (xfer_ok) begin
                        state_q    <= S_FINISH;
                        avm_read_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        if (rd_value > LAST_CELL) begin
                            err_q    <= 1'b1;
                            target_q <= '0;
                        end else begin
                            err_q    <= 1'b0;
                            target_q <= rd_value;
                        end
                    end
                end

                // done is high during this state; any req here is dropped
                S_FINISH: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.target_index  = target_q;
    assign bus.avm_address   = avm_address_q;
    assign bus.avm_write     = avm_write_q;
    assign bus.avm_read      = avm_read_q;
    assign bus.avm_writedata = avm_writedata_q;

endmodule
